// File: rtl/ram_read_streamer.sv
// Streams a burst of consecutive RAM words onto a valid/ready output.
// Reads are credit-limited so a 2-entry output buffer can never overflow.
module ram_read_streamer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH:0]   start_length,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data,
  output logic                     stream_valid,
  input  logic                     stream_ready,
  output logic [WIDTH-1:0]         stream_data,
  output logic                     stream_last,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LEN = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   ONE_LEN   = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH-1);
  localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR  = ADDRESS_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
  logic                     pending_q, pending_d;
  logic                     pending_last_q, pending_last_d;
  logic [1:0]               occ_q, occ_d;
  logic [WIDTH-1:0]         data0_q, data0_d;
  logic [WIDTH-1:0]         data1_q, data1_d;
  logic                     last0_q, last0_d;
  logic                     last1_q, last1_d;

  logic                     start_fire;
  logic                     stream_fire;
  logic                     issue;
  logic [ADDRESS_WIDTH:0]   sat_length;
  logic [2:0]               credit;

  // Handshakes and read credit: a read may go out only if the buffer will still
  // have a free slot when its data lands one cycle later.
  always_comb begin
    start_fire  = start_valid && (state_q == IDLE);
    stream_fire = (occ_q != 2'd0) && stream_ready;
    credit      = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, stream_fire};
    issue       = (state_q == READ) && (remaining_q != '0) && (credit <= 3'd1);
    sat_length  = (start_length > DEPTH_LEN) ? DEPTH_LEN : start_length;
  end

  // Next-state logic for the burst sequencer and the output buffer.
  always_comb begin
    state_d        = state_q;
    next_addr_d    = next_addr_q;
    last_addr_d    = last_addr_q;
    remaining_d    = remaining_q;
    pending_d      = issue;
    pending_last_d = issue && (remaining_q == ONE_LEN);
    occ_d          = occ_q;
    data0_d        = data0_q;
    data1_d        = data1_q;
    last0_d        = last0_q;
    last1_d        = last1_q;

    case (state_q)
      IDLE: begin
        if (start_fire && (sat_length != '0)) begin
          next_addr_d = start_address;
          remaining_d = sat_length;
          state_d     = READ;
        end
      end
      READ: begin
        if (issue) begin
          next_addr_d = (next_addr_q == LAST_ADDR) ? '0 : next_addr_q + ONE_ADDR;
          last_addr_d = next_addr_q;
          remaining_d = remaining_q - ONE_LEN;
          if (remaining_q == ONE_LEN) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (stream_fire && last0_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({pending_q, stream_fire})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          data0_d = ram_read_data;
          last0_d = pending_last_q;
        end else begin
          data1_d = ram_read_data;
          last1_d = pending_last_q;
        end
      end
      2'b01: begin
        occ_d   = occ_q - 2'd1;
        data0_d = data1_q;
        last0_d = last1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = ram_read_data;
          last0_d = pending_last_q;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = ram_read_data;
          last1_d = pending_last_q;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset abandons any burst and drops in-flight RAM data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= IDLE;
      next_addr_q    <= '0;
      last_addr_q    <= '0;
      remaining_q    <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      occ_q          <= 2'd0;
      data0_q        <= '0;
      data1_q        <= '0;
      last0_q        <= 1'b0;
      last1_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_addr_q    <= next_addr_d;
      last_addr_q    <= last_addr_d;
      remaining_q    <= remaining_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      occ_q          <= occ_d;
      data0_q        <= data0_d;
      data1_q        <= data1_d;
      last0_q        <= last0_d;
      last1_q        <= last1_d;
    end
  end

  assign start_ready      = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign ram_read_enable  = issue;
  assign ram_read_address = issue ? next_addr_q : last_addr_q;
  assign stream_valid     = (occ_q != 2'd0);
  assign stream_data      = data0_q;
  assign stream_last      = (occ_q != 2'd0) && last0_q;

endmodule
